// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: reusable pipeline-stage register with valid/ready handshake,
// flush, and separate data/control payloads. Control is zeroed whenever the
// stage holds no valid beat; data keeps its last value.
//
// Build option: define PIPE_STAGE_SKID_EN for a 2-entry skid buffer with a
// registered s_ready (no combinational path from m_ready). Undefined gives a
// single entry with s_ready = ~m_valid | m_ready.
//
// Skid-build states:
//   state | meaning
//   EMPTY | no beat held, s_ready=1
//   ONE   | main entry valid, skid empty, s_ready=1
//   FULL  | main and skid valid, s_ready=0

module pipe_stage_reg #(
  parameter int                 DATA_W   = 32,
  parameter int                 CTRL_W   = 8,
  parameter logic [DATA_W-1:0]  DATA_RST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [CTRL_W-1:0] s_ctrl,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CTRL_W-1:0] m_ctrl
);

`ifdef PIPE_STAGE_SKID_EN

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t            state;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              s_ready_q;
  logic              in_xfer;
  logic              out_xfer;

  assign s_ready  = s_ready_q;
  assign in_xfer  = s_valid & s_ready_q;
  assign out_xfer = m_valid & m_ready;

  // Occupancy FSM; main entry drives m_*, skid catches the beat accepted while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      s_ready_q <= 1'b1;
      m_valid   <= 1'b0;
      m_data    <= DATA_RST;
      m_ctrl    <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      // Flush wins over any handshake; the offered beat is dropped and data is kept
      state     <= EMPTY;
      s_ready_q <= 1'b1;
      m_valid   <= 1'b0;
      m_ctrl    <= '0;
      skid_ctrl <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            m_data  <= s_data;
            m_ctrl  <= s_ctrl;
            m_valid <= 1'b1;
            state   <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && !out_xfer) begin
            skid_data <= s_data;
            skid_ctrl <= s_ctrl;
            s_ready_q <= 1'b0;
            state     <= FULL;
          end else if (in_xfer && out_xfer) begin
            m_data <= s_data;
            m_ctrl <= s_ctrl;
          end else if (out_xfer) begin
            m_valid <= 1'b0;
            m_ctrl  <= '0;
            state   <= EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            m_data    <= skid_data;
            m_ctrl    <= skid_ctrl;
            skid_ctrl <= '0;
            s_ready_q <= 1'b1;
            state     <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          s_ready_q <= 1'b1;
          m_valid   <= 1'b0;
          m_ctrl    <= '0;
        end
      endcase
    end
  end

`else

  // Single entry can take a new beat when empty or when its beat leaves this cycle
  assign s_ready = ~m_valid | m_ready;

  // Single-entry stage register; control clears when the entry empties
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= DATA_RST;
      m_ctrl  <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      m_ctrl  <= '0;
    end else if (s_valid && s_ready) begin
      m_valid <= 1'b1;
      m_data  <= s_data;
      m_ctrl  <= s_ctrl;
    end else if (m_ready) begin
      m_valid <= 1'b0;
      m_ctrl  <= '0;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed + randomized bench for pipe_stage_reg; works for either build.
module tb_pipe_stage_reg;

  localparam logic [31:0] RST_VAL = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [7:0]  s_ctrl;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [7:0]  m_ctrl;

  int errors = 0;
  int checks = 0;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .DATA_RST(RST_VAL)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_ctrl(s_ctrl),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_ctrl(m_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [39:0] q[$];
  logic [31:0] outs[$];
  logic [31:0] pend[$];
  logic        exp_rdy;
  logic        skid_build;

  initial begin
`ifdef PIPE_STAGE_SKID_EN
    skid_build = 1'b1;
`else
    skid_build = 1'b0;
`endif
    rst = 0; flush = 0; s_valid = 0; s_data = '0; s_ctrl = '0; m_ready = 0;

    // Reset asserted between edges
    #2 rst = 1;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_ctrl", m_ctrl, 0);
    chk("rst_m_data", m_data, RST_VAL);
    chk("rst_s_ready", s_ready, 1);
    tick(); tick();
    chk("rst_hold_s_ready", s_ready, 1);
    @(negedge clk); rst = 0;
    tick();
    chk("post_rst_s_ready", s_ready, 1);
    chk("post_rst_m_valid", m_valid, 0);

    // Streaming 1..16 at full rate
    m_ready = 1; s_valid = 1; s_ctrl = 8'h03;
    for (int i = 1; i <= 16; i++) begin
      s_data = i;
      #1 chk("stream_s_ready", s_ready, 1);
      tick();
      chk("stream_m_valid", m_valid, 1);
      chk("stream_m_data", m_data, i);
      chk("stream_m_ctrl", m_ctrl, 8'h03);
    end
    s_valid = 0;
    tick();
    chk("drain_m_valid", m_valid, 0);
    chk("drain_m_ctrl", m_ctrl, 0);
    chk("drain_m_data_hold", m_data, 32'h10);

    // Back-pressure: m_ready low for 3 cycles while pushing A,B,C
    m_ready = 0; s_valid = 1; s_data = 32'hA; s_ctrl = 8'h11;
    #1 chk("bp_s_ready_empty", s_ready, 1);
    tick();
    chk("bp_hold_A", m_data, 32'hA);
    s_data = 32'hB; s_ctrl = 8'h12;
    #1 chk("bp_s_ready_after_A", s_ready, skid_build ? 1 : 0);
    tick();
    chk("bp_stall_data", m_data, 32'hA);
    chk("bp_stall_ctrl", m_ctrl, 8'h11);
    chk("bp_stall_valid", m_valid, 1);
    chk("bp_s_ready_full", s_ready, 0);
    if (skid_build) begin
      pend.push_back(32'hC);
    end else begin
      pend.push_back(32'hB);
      pend.push_back(32'hC);
    end
    s_data = pend[0]; s_ctrl = pend[0][7:0] + 8'h6;
    tick();
    chk("bp_stall3_data", m_data, 32'hA);
    // Release and drain
    m_ready = 1;
    for (int c = 0; c < 10; c++) begin
      s_valid = (pend.size() != 0);
      if (pend.size() != 0) begin
        s_data = pend[0];
        s_ctrl = pend[0][7:0] + 8'h6;
      end
      #1;
      if (m_valid && m_ready) outs.push_back(m_data);
      if (s_valid && s_ready) void'(pend.pop_front());
      tick();
    end
    s_valid = 0;
    chk("bp_out_count", outs.size(), 3);
    if (outs.size() == 3) begin
      chk("bp_out0", outs[0], 32'hA);
      chk("bp_out1", outs[1], 32'hB);
      chk("bp_out2", outs[2], 32'hC);
    end
    chk("bp_empty", m_valid, 0);

    // Flush with a simultaneous new beat
    m_ready = 0; s_valid = 1; s_data = 32'h55; s_ctrl = 8'h01;
    tick();
    chk("fl_hold_data", m_data, 32'h55);
    chk("fl_hold_ctrl", m_ctrl, 8'h01);
    flush = 1; s_data = 32'h66; s_ctrl = 8'h02;
    tick();
    flush = 0; s_valid = 0;
    chk("fl_m_valid", m_valid, 0);
    chk("fl_m_ctrl", m_ctrl, 0);
    chk("fl_m_data_kept", m_data, 32'h55);
    chk("fl_s_ready", s_ready, 1);
    m_ready = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("fl_no_66", m_valid, 0);
    end

    // Reset mid-operation with a beat held
    m_ready = 0; s_valid = 1; s_data = 32'h77; s_ctrl = 8'h05;
    tick();
    s_valid = 0;
    chk("mid_loaded", m_data, 32'h77);
    #3 rst = 1;
    #1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_ctrl", m_ctrl, 0);
    chk("mid_rst_data", m_data, RST_VAL);
    chk("mid_rst_s_ready", s_ready, 1);
    @(negedge clk); rst = 0;
    tick();

    // Random handshake against a queue model
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 31) == 0);
      s_data  = $urandom;
      s_ctrl  = $urandom_range(0, 255);
      #1;
      exp_rdy = skid_build ? (q.size() < 2) : ((q.size() == 0) || m_ready);
      chk("rnd_s_ready", s_ready, exp_rdy);
      chk("rnd_m_valid", m_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("rnd_m_data", m_data, q[0][39:8]);
        chk("rnd_m_ctrl", m_ctrl, q[0][7:0]);
      end else begin
        chk("rnd_m_ctrl_idle", m_ctrl, 0);
      end
      if (flush) begin
        q.delete();
      end else begin
        if ((q.size() != 0) && m_ready) void'(q.pop_front());
        if (s_valid && exp_rdy) q.push_back({s_data, s_ctrl});
      end
      tick();
    end
    flush = 0; s_valid = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage register with a valid/ready handshake, flush, and separate data and control payloads. It replaces fixed-width, always-enabled stage DFF banks (IF/ID … MEM/WB) with one reusable stage that can stall on back-pressure and squash control on flush. An optional 2-entry skid buffer removes the combinational ready path for timing-critical boundaries.

## Interface
- `DATA_W`, default 32: width of the data payload (operands, results, memory read data).
- `CTRL_W`, default 8: width of the control payload (e.g. register write enable, memory read enable); cleared on flush.
- `DATA_RST`, default 0: value of `m_data` after reset.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `flush`  in  1: squash stage contents and the beat offered this cycle.
- `s_valid`  in  1: upstream beat valid.
- `s_ready`  out  1: stage can accept a beat.
- `s_data`  in  DATA_W: upstream data payload.
- `s_ctrl`  in  CTRL_W: upstream control payload.
- `m_valid`  out  1: downstream beat valid.
- `m_ready`  in  1: downstream accepts the beat.
- `m_data`  out  DATA_W: downstream data payload.
- `m_ctrl`  out  CTRL_W: downstream control payload; all-zero whenever `m_valid`=0.

## Operation
- Transfer in: `s_valid & s_ready` at a rising edge. Transfer out: `m_valid & m_ready` at a rising edge.
- Beats leave in the order they arrive. Beats are never duplicated and never dropped, except on flush.
- Default build (no skid) has a single entry:
  - `s_ready = ~m_valid | m_ready`, a combinational path from `m_ready`.
  - On an accepted beat, the entry loads `s_data` and `s_ctrl` and sets `m_valid`.
  - On an out-transfer with no in-transfer, `m_valid` clears and `m_ctrl` clears to 0. `m_data` holds its last value.
- Skid build uses a main entry and a skid entry. States: EMPTY, ONE, FULL.
  - EMPTY, accept: go to ONE.
  - ONE, accept with no out-transfer: the new beat goes to the skid entry; go to FULL.
  - ONE, out-transfer with no accept: go to EMPTY.
  - ONE, accept and out-transfer: the new beat loads main; stay in ONE.
  - FULL, out-transfer: skid moves to main; go to ONE.
  - `s_ready` is registered: it equals `~FULL`.
- Flush has priority over every other event:
  - Next state is EMPTY. `m_valid` = 0 and `m_ctrl` = 0.
  - A beat offered in the same cycle is discarded, even though `s_ready` may read 1.
  - `m_data` is not cleared.
- Data and control in an entry are always written together. A partial update never happens.

## Timing
- Reset values: `m_valid`=0, `m_ctrl`=0, `m_data`=`DATA_RST`.
  - Default build: `s_ready`=1 during and after reset.
  - Skid build: `s_ready`=1 during and after reset.
- Latency is 1 cycle. A beat accepted at edge N is visible on `m_*` after edge N.
- Throughput is 1 beat/cycle in both builds while `m_ready`=1.
- Stall (`m_ready`=0, `m_valid`=1): `m_valid`, `m_data` and `m_ctrl` stay stable until the out-transfer.
- Reset asserted mid-operation: all entries are cleared immediately, without waiting for a clock edge. Any in-flight beats are lost.
- Flush takes effect on the edge where it is sampled high. The stage is empty from the next cycle on.

## Configuration
- Macro `PIPE_STAGE_SKID_EN`.
- Defined:
  - 2-entry skid buffer; `s_ready` is a flop output with no path from `m_ready`.
  - Adds DATA_W+CTRL_W+1 flops.
- Undefined:
  - Single entry; `s_ready` depends combinationally on `m_ready`.
  - Behaviour seen at the `m_*` side is identical for any stimulus in which `m_ready` never drops.

## Test plan
- **Reset:** assert `rst` asynchronously between edges → `m_valid`=0, `m_ctrl`=0 and `m_data`=`DATA_RST` immediately, without a clock edge; `s_ready`=1.
- **Streaming:** `m_ready`=1, push 0x1..0x10 with `s_ctrl`=0x03 → the same sequence appears on `m_data` one cycle later with `m_ctrl`=0x03, at 1 beat/cycle.
- **Back-pressure:** push 0xA, 0xB, 0xC with `m_ready`=0 for 3 cycles.
  - Default build: `s_ready`=0 after 0xA is held.
  - Skid build: 0xA and 0xB are held, then `s_ready`=0.
  - After release, output is 0xA, 0xB, 0xC in order with no loss.
- **Flush with a new beat:** stage holds 0x55 with `m_ctrl`=0x01; assert `flush` together with `s_valid` carrying 0x66 → next cycle `m_valid`=0 and `m_ctrl`=0x00, and 0x66 never appears.
- **Random handshake:** random `s_valid`/`m_ready`/`flush` for 10k cycles → scoreboard matches in-order delivery minus flushed beats. In the skid build, a skid-entry beat is delivered after the main-entry beat and before any newer beat.
